// File: rtl/wire_debouncer_if.sv
// Signal bundle between the wire header conditioning stage and its consumers.
// The slave side is the debouncer itself; the master side supplies raw pins and reads clean levels.
interface wire_debouncer_if #(
    parameter int WIDTH = 6
);
    logic [WIDTH-1:0] wire_raw;
    logic [WIDTH-1:0] wire_clean;
    logic [WIDTH-1:0] cut_pulse;
    logic [WIDTH-1:0] insert_pulse;
    logic             wire_changed;
    logic [2:0]       wire_count;
    logic             settled;

    modport master (
        output wire_raw,
        input  wire_clean,
        input  cut_pulse,
        input  insert_pulse,
        input  wire_changed,
        input  wire_count,
        input  settled
    );

    modport slave (
        input  wire_raw,
        output wire_clean,
        output cut_pulse,
        output insert_pulse,
        output wire_changed,
        output wire_count,
        output settled
    );
endinterface

// File: rtl/wire_debouncer.sv
// Synchronises and debounces the wire header pins, producing clean levels,
// one-cycle cut/insert pulses (suppressed until power-up settle) and a popcount.
module wire_debouncer #(
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input logic            clk,
    input logic            rst,
    wire_debouncer_if.slave bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SET_W = $clog2(DEBOUNCE_CYCLES + 3);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(DEBOUNCE_CYCLES + 2);

    logic [WIDTH-1:0] sync1_p0;
    logic [WIDTH-1:0] sync2_p1;
    logic [CNT_W-1:0] mis_cnt_p1 [WIDTH];
    logic [WIDTH-1:0] clean_p2;
    logic [WIDTH-1:0] cut_p2;
    logic [WIDTH-1:0] insert_p2;
    logic             changed_p2;
    logic [SET_W-1:0] settle_cnt;
    logic             settled;
    logic [WIDTH-1:0] accept;

    function automatic logic [2:0] popcount(input logic [WIDTH-1:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + 3'(v[i]);
        end
        return c;
    endfunction

    // A bit is accepted on the edge its mismatch run reaches DEBOUNCE_CYCLES.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (sync2_p1[i] != clean_p2[i]) && (mis_cnt_p1[i] == CNT_LAST);
        end
    end

    // Stage p0/p1: two-flop synchroniser into the mismatch counters
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_p0 <= '0;
            sync2_p1 <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                mis_cnt_p1[i] <= '0;
            end
        end else begin
            sync1_p0 <= bus.wire_raw;
            sync2_p1 <= sync1_p0;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_p1[i] == clean_p2[i] || accept[i]) begin
                    mis_cnt_p1[i] <= '0;
                end else begin
                    mis_cnt_p1[i] <= mis_cnt_p1[i] + CNT_W'(1);
                end
            end
        end
    end

    // Stage p2: clean levels and edge pulses, gated by the settle window
    always_ff @(posedge clk) begin
        if (rst) begin
            clean_p2   <= '0;
            cut_p2     <= '0;
            insert_p2  <= '0;
            changed_p2 <= 1'b0;
        end else begin
            clean_p2   <= clean_p2 ^ accept;
            cut_p2     <= settled ? (accept & clean_p2)  : '0;
            insert_p2  <= settled ? (accept & ~clean_p2) : '0;
            changed_p2 <= settled && (|accept);
        end
    end

    // Settle window: rises DEBOUNCE_CYCLES+2 edges after reset release, one past the
    // acceptance of levels held from reset, so connected wires never pulse at power-up.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
            settled    <= 1'b0;
        end else if (!settled) begin
            if (settle_cnt == SET_LAST) begin
                settled <= 1'b1;
            end else begin
                settle_cnt <= settle_cnt + SET_W'(1);
            end
        end
    end

    assign bus.wire_clean   = clean_p2;
    assign bus.cut_pulse    = cut_p2;
    assign bus.insert_pulse = insert_p2;
    assign bus.wire_changed = changed_p2;
    assign bus.wire_count   = popcount(clean_p2);
    assign bus.settled      = settled;
endmodule

// File: tb/tb_wire_debouncer.sv
// Bench for wire_debouncer: directed wire scenarios plus random pin activity,
// checked every cycle against a sliding-window model of the debounce rules.
module tb_wire_debouncer;
    localparam int W  = 6;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wire_debouncer_if #(.WIDTH(W)) bus();
    wire_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;

    logic [W-1:0] hist [0:4095];
    int n;
    int last [W];
    logic [W-1:0] clean_m, cut_m, ins_m;
    logic         chg_m, set_m;

    logic [W-1:0] cut_acc, ins_acc;
    int           chg_n;
    logic [W-1:0] r;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] sample(input int e);
        if (e < 0) return '0;
        return hist[e];
    endfunction

    // Bit i is accepted at edge n if the synchronised pin (raw from two edges earlier)
    // differed from the clean level on each of the last DC edges, all after its previous change.
    task automatic model_edge();
        logic [W-1:0] s;
        logic acc;
        int e;
        cut_m = '0;
        ins_m = '0;
        for (int i = 0; i < W; i++) begin
            acc = 1'b1;
            for (int j = 0; j < DC; j++) begin
                e = n - j;
                s = sample(e - 2);
                if (e <= last[i]) acc = 1'b0;
                else if (s[i] == clean_m[i]) acc = 1'b0;
            end
            if (acc) begin
                clean_m[i] = ~clean_m[i];
                last[i] = n;
                if (n >= DC + 3) begin
                    if (clean_m[i]) ins_m[i] = 1'b1;
                    else cut_m[i] = 1'b1;
                end
            end
        end
        chg_m = |(cut_m | ins_m);
        set_m = (n >= DC + 2);
    endtask

    task automatic reset_model();
        n = 0;
        clean_m = '0;
        for (int i = 0; i < W; i++) last[i] = -1;
    endtask

    task automatic clr_acc();
        cut_acc = '0;
        ins_acc = '0;
        chg_n = 0;
    endtask

    task automatic step(input logic [W-1:0] raw);
        @(negedge clk);
        rst = 1'b0;
        bus.wire_raw = raw;
        hist[n] = raw;
        @(posedge clk);
        model_edge();
        #1;
        chk("wire_clean",   32'(bus.wire_clean),   32'(clean_m));
        chk("cut_pulse",    32'(bus.cut_pulse),    32'(cut_m));
        chk("insert_pulse", 32'(bus.insert_pulse), 32'(ins_m));
        chk("wire_changed", 32'(bus.wire_changed), 32'(chg_m));
        chk("wire_count",   32'(bus.wire_count),   32'($countones(clean_m)));
        chk("settled",      32'(bus.settled),      32'(set_m));
        cut_acc |= bus.cut_pulse;
        ins_acc |= bus.insert_pulse;
        if (bus.wire_changed) chg_n++;
        n++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_clean",   32'(bus.wire_clean),   32'd0);
        chk("rst_cut",     32'(bus.cut_pulse),    32'd0);
        chk("rst_insert",  32'(bus.insert_pulse), 32'd0);
        chk("rst_changed", 32'(bus.wire_changed), 32'd0);
        chk("rst_count",   32'(bus.wire_count),   32'd0);
        chk("rst_settled", 32'(bus.settled),      32'd0);
        reset_model();
    endtask

    initial begin
        bus.wire_raw = '0;
        reset_model();
        do_reset();
        do_reset();

        // All wires connected from reset release: level accepted, no pulses
        clr_acc();
        r = 6'b111111;
        repeat (10) step(r);
        chk("pwr_no_pulse", 32'(chg_n), 32'd0);
        chk("pwr_clean", 32'(bus.wire_clean), 32'h3f);

        // Cut bit 2
        clr_acc();
        r = 6'b111011;
        repeat (8) step(r);
        chk("cut2_mask", 32'(cut_acc), 32'h04);
        chk("cut2_ins", 32'(ins_acc), 32'h00);
        chk("cut2_events", 32'(chg_n), 32'd1);

        // Three-cycle glitch on bit 0
        clr_acc();
        repeat (3) step(6'b111010);
        repeat (6) step(r);
        chk("glitch_events", 32'(chg_n), 32'd0);
        chk("glitch_clean", 32'(bus.wire_clean), 32'h3b);

        // Bits 1 and 4 cut together
        clr_acc();
        r = 6'b101001;
        repeat (8) step(r);
        chk("cut14_mask", 32'(cut_acc), 32'h12);
        chk("cut14_events", 32'(chg_n), 32'd1);

        // Cut then reinsert bit 3
        r = 6'b100001;
        repeat (8) step(r);
        clr_acc();
        r = 6'b101001;
        repeat (8) step(r);
        chk("ins3_mask", 32'(ins_acc), 32'h08);
        chk("ins3_cut", 32'(cut_acc), 32'h00);
        chk("ins3_events", 32'(chg_n), 32'd1);

        // Random pin activity with glitches of varying length
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) r[$urandom_range(0, W - 1)] ^= 1'b1;
            step(r);
        end

        // Reset while bit 0 is mid-debounce (counter at 2)
        repeat (DC + 3) step(r);
        r[0] = ~r[0];
        repeat (4) step(r);
        do_reset();
        clr_acc();
        repeat (12) step(r);
        chk("rst_settle_events", 32'(chg_n), 32'd0);

        // Random activity starting inside a fresh settle window
        do_reset();
        repeat (200) begin
            if ($urandom_range(0, 2) == 0) r[$urandom_range(0, W - 1)] ^= 1'b1;
            step(r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wire_debouncer.md
# wire_debouncer

Input-conditioning stage between the six physical wire header pins and the wire-cutting puzzle logic. It synchronises each raw pin, debounces it with a per-bit stability counter, and presents a clean level vector plus one-cycle cut/insert pulses and a population count. The wire-puzzle module and game controller consume `wire_clean` as their `wire_in`; pulses are suppressed during a power-up settle window so initially connected wires never register as events.

## Interface
- `WIDTH`, 6, number of wire pins
- `DEBOUNCE_CYCLES`, 50000, consecutive stable cycles required to accept a new level (1 ms at 50 MHz); legal range 1..2^20

- `clk`  in  1  system clock; one clock domain
- `rst`  in  1  synchronous, active-high reset
- `wire_raw`  in  WIDTH  asynchronous pin levels (1 = wire connected, 0 = cut/absent)
- `wire_clean`  out  WIDTH  debounced level, registered
- `cut_pulse`  out  WIDTH  one-cycle pulse per bit on accepted 1→0
- `insert_pulse`  out  WIDTH  one-cycle pulse per bit on accepted 0→1
- `wire_changed`  out  1  one-cycle pulse, OR of all cut/insert pulses
- `wire_count`  out  3  number of ones in `wire_clean`
- `settled`  out  1  high once the power-up settle window has elapsed

## Operation
- Per bit: two-flop synchroniser `sync1 → sync2`; both reset to 0.
- Per bit: mismatch counter, width ceil(log2(DEBOUNCE_CYCLES+1)), reset 0.
  - Edge with `sync2 == wire_clean[i]`: counter ← 0.
  - Edge with mismatch and counter < DEBOUNCE_CYCLES−1: counter ← counter+1.
  - Edge with mismatch and counter == DEBOUNCE_CYCLES−1: `wire_clean[i] ← sync2`, counter ← 0, and the matching pulse is asserted if `settled` is 1.
- Glitch shorter than DEBOUNCE_CYCLES consecutive mismatch edges: counter returns to 0, no level change, no pulse.
- Bits are fully independent; simultaneous acceptance on several bits sets several pulse bits in the same cycle, with one `wire_changed` pulse.
- Settle counter: counts edges after reset deassertion; `settled` ← 1 on the (DEBOUNCE_CYCLES+2)-th edge, then stays 1 until reset. While `settled` = 0, `wire_clean` still updates but all pulses are forced to 0.
- `wire_count`: combinational popcount of `wire_clean`, range 0..6, no overflow at WIDTH = 6.
- Reset (any cycle, including mid-debounce): all synchroniser flops, counters, `wire_clean`, pulses, and `settled` clear to 0 on the same edge; in-progress debounce is discarded.

## Timing
- Reset values: `wire_clean` = 0, `cut_pulse` = 0, `insert_pulse` = 0, `wire_changed` = 0, `wire_count` = 0, `settled` = 0.
- Latency: raw level first sampled at edge k and held → `sync2` updated at k+1 → `wire_clean` and pulse updated at edge k+1+DEBOUNCE_CYCLES.
- Pulses are exactly one cycle wide and registered on the same edge as the `wire_clean` update.
- A level held stable from reset is accepted at edge DEBOUNCE_CYCLES+1. This is one edge before `settled` rises, so no pulse is produced.
- No handshake: consumers sample levels and pulses every cycle.

## Test plan
- DEBOUNCE_CYCLES = 4; `wire_raw` = 6'b111111 from reset release (edge 0): `wire_clean` = 111111 at edge 5, `wire_count` = 6, `settled` = 1 at edge 6, no pulses at any point.
- After settle, drop bit 2 at edge k and hold: `wire_clean` = 111011 at k+5; `cut_pulse` = 000100 and `wire_changed` = 1 for exactly that cycle; `wire_count` = 5.
- After settle, bit 0 low for 3 cycles, then high again: no change to `wire_clean`, no pulses, counter back at 0.
- Bits 1 and 4 cut at the same edge: a single cycle with `cut_pulse` = 010010 and one `wire_changed` pulse.
- Bit 3 reinserted (0→1) and held: `insert_pulse` = 001000 for one cycle; `cut_pulse` stays 0.
- Assert `rst` mid-debounce (counter = 2): next edge shows all outputs 0 and `settled` = 0; the settle window restarts with no spurious pulse.
